// File: rtl/digit_display_driver.sv
// Four-digit multiplexed 7-segment driver with shadow capture and atomic frame commit.
// Latency: one clk from the scan position (cnt, scan_idx) to seg/dp/an; commits show on the next output update.
// Backpressure: none; the block follows display_select every cycle and never stalls the producer.
//
// Ports:
//   clk, rst            - system clock, asynchronous active-high reset
//   ms, display_select  - lagged BCD digit stream and its rotating slot counter
//   react, blank_en     - decimal-point request, leading-zero blanking enable
//   seg, dp, an         - active-low segments {g,f,e,d,c,b,a}, decimal point, digit anodes
//   frame_ready         - set by the first committed frame, cleared only by rst
module digit_display_driver #(
    parameter int SCAN_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ms,
    input  logic [1:0] display_select,
    input  logic       react,
    input  logic       blank_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_ready
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [3:0]    shadow [4];
    logic [3:0]    disp   [4];
    logic [CW-1:0] cnt;
    logic [1:0]    scan_idx;
    logic          react_q;

    logic [1:0]    cap_idx;
    logic          cnt_wrap;
    logic [3:0]    slot_zero;
    logic [3:0]    blank;
    logic [3:0]    cur_digit;
    logic          cur_blank;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = 7'h3F;  // non-BCD shows a dash
        endcase
        return g;
    endfunction

    // The producer presents ms one slot behind display_select.
    assign cap_idx  = display_select - 2'd1;
    assign cnt_wrap = (cnt == CNT_LAST);

    // Shadow capture: every edge, unconditionally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
        end else begin
            shadow[cap_idx] <= ms;
        end
    end

    // Atomic commit. At display_select==0 the slot-3 digit is still on ms,
    // so it is taken directly rather than from its shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) disp[i] <= '0;
            frame_ready <= 1'b0;
        end else if (display_select == 2'd0) begin
            disp[3]     <= ms;
            disp[2]     <= shadow[2];
            disp[1]     <= shadow[1];
            disp[0]     <= shadow[0];
            frame_ready <= 1'b1;
        end
    end

    // Scan prescaler and slot index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            scan_idx <= 2'd0;
        end else if (cnt_wrap) begin
            cnt      <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            cnt      <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) react_q <= 1'b0;
        else     react_q <= react;
    end

    // Leading-zero blanking from the committed frame: a slot blanks only if
    // it and every slot above it are zero. Slot 0 always shows.
    always_comb begin
        for (int i = 0; i < 4; i++) slot_zero[i] = (disp[i] == 4'd0);
        blank    = 4'b0000;
        blank[3] = blank_en & slot_zero[3];
        blank[2] = blank[3] & slot_zero[2];
        blank[1] = blank[2] & slot_zero[1];
    end

    assign cur_digit = disp[scan_idx];
    assign cur_blank = blank[scan_idx];

    // cnt==0 forces all anodes off: one dark cycle between slots prevents ghosting.
    always_comb begin
        an_nxt  = 4'b1111;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (!cur_blank) begin
            seg_nxt = decode(cur_digit);
            if (cnt != '0) begin
                an_nxt = ~(4'b0001 << scan_idx);
                dp_nxt = ~((scan_idx == 2'd0) & react_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_digit_display_driver.sv
module tb_digit_display_driver;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ms = 4'd0;
    logic [1:0] display_select = 2'd1;
    logic       react = 1'b0;
    logic       blank_en = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_ready;

    int tests = 0;
    int fails = 0;

    // Reference model state: the frame the display is expected to show.
    int model_frame [4];
    bit model_blank_en;
    bit model_react;

    digit_display_driver #(.SCAN_DIV(N)) dut (
        .clk(clk), .rst(rst), .ms(ms), .display_select(display_select),
        .react(react), .blank_en(blank_en), .seg(seg), .dp(dp), .an(an),
        .frame_ready(frame_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int v);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (v >= 0 && v <= 9) return tbl[v];
        return 7'h3F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame through the lagged protocol: display_select 1,2,3,0
    // with ms carrying the digit of the slot before display_select.
    task automatic load_frame(input int f [4]);
        int order [4];
        order = '{1, 2, 3, 0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            display_select = 2'(order[k]);
            ms = 4'(f[(order[k] + 3) % 4]);
        end
        @(negedge clk);
        display_select = 2'd1;
        ms = 4'(f[0]);
        for (int i = 0; i < 4; i++) model_frame[i] = f[i];
    endtask

    task automatic set_mode(input bit b, input bit r);
        @(negedge clk);
        blank_en = b;
        react = r;
        model_blank_en = b;
        model_react = r;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Observe one full scan period and check it against the model frame:
    // every lit cycle shows the right slot/glyph/dp, each unblanked slot is
    // lit N-1 cycles, and the remaining cycles are dark.
    task automatic check_window(input string tag);
        int  lit [4];
        int  dark;
        bit  bl [4];
        bit  all_zero;
        int  exp_dark;
        for (int s = 0; s < 4; s++) begin
            all_zero = 1'b1;
            for (int j = s; j < 4; j++) if (model_frame[j] != 0) all_zero = 1'b0;
            bl[s] = model_blank_en && (s >= 1) && all_zero;
            lit[s] = 0;
        end
        dark = 0;
        for (int c = 0; c < 4 * N; c++) begin
            @(negedge clk);
            if (an === 4'b1111) begin
                dark++;
                chk({tag, ".dp_dark"}, 32'(dp), 32'd1);
            end else begin
                int s;
                s = -1;
                for (int i = 0; i < 4; i++) if (an === ~(4'b0001 << i)) s = i;
                chk({tag, ".an_onehot"}, 32'(s >= 0), 32'd1);
                if (s >= 0) begin
                    lit[s]++;
                    chk($sformatf("%s.seg%0d", tag, s), 32'(seg), 32'(glyph(model_frame[s])));
                    chk($sformatf("%s.dp%0d", tag, s), 32'(dp),
                        32'(!(s == 0 && model_react)));
                end
            end
        end
        exp_dark = 4;
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("%s.lit%0d", tag, s), 32'(lit[s]), bl[s] ? 32'd0 : 32'(N - 1));
            if (bl[s]) exp_dark += N - 1;
        end
        chk({tag, ".dark"}, 32'(dark), 32'(exp_dark));
    endtask

    initial begin
        int f [4];
        int budget;

        for (int i = 0; i < 4; i++) model_frame[i] = 0;
        model_blank_en = 1'b0;
        model_react = 1'b0;

        // Reset state.
        #12;
        chk("rst.an", 32'(an), 32'hF);
        chk("rst.seg", 32'(seg), 32'h7F);
        chk("rst.dp", 32'(dp), 32'd1);
        chk("rst.frame_ready", 32'(frame_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Before any commit the display holds zeros.
        set_mode(1'b0, 1'b0);
        chk("pre.frame_ready", 32'(frame_ready), 32'd0);
        check_window("pre");

        // Frame 1,2,0,3 (slot3..slot0).
        f = '{3, 0, 2, 1};
        load_frame(f);
        chk("f1203.frame_ready", 32'(frame_ready), 32'd1);
        check_window("f1203");

        // Leading-zero blanking, on and off.
        set_mode(1'b1, 1'b0);
        f = '{5, 0, 0, 0};
        load_frame(f);
        check_window("f0005.blank");
        set_mode(1'b0, 1'b0);
        check_window("f0005.noblank");

        // Non-BCD value in slot 2.
        f = '{0, 0, 12, 0};
        load_frame(f);
        check_window("dash");

        // Decimal point with react.
        set_mode(1'b0, 1'b1);
        check_window("react1");
        set_mode(1'b0, 1'b0);
        check_window("react0");

        // Anti-tearing: new slot-0 digit captured, old frame stays until commit.
        f = '{4, 6, 8, 9};
        load_frame(f);
        @(negedge clk);
        display_select = 2'd1;
        ms = 4'd7;
        @(negedge clk);
        display_select = 2'd2;
        ms = 4'(f[1]);
        check_window("tear.hold");
        @(negedge clk);
        display_select = 2'd3;
        ms = 4'(f[2]);
        @(negedge clk);
        display_select = 2'd0;
        ms = 4'(f[3]);
        @(negedge clk);
        display_select = 2'd1;
        ms = 4'd7;
        model_frame[0] = 7;
        check_window("tear.commit");

        // Randomized frames, blanking and react.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 4; i++)
                f[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15));
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            load_frame(f);
            check_window($sformatf("rand%0d", t));
        end

        // Reset mid-scan while slot 1 is lit.
        set_mode(1'b0, 1'b1);
        f = '{0, 0, 0, 0};
        load_frame(f);
        budget = 8 * N;
        while (an !== 4'b1101 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("midrst.found_slot1", 32'(an), 32'hD);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.an", 32'(an), 32'hF);
        chk("midrst.seg", 32'(seg), 32'h7F);
        chk("midrst.dp", 32'(dp), 32'd1);
        chk("midrst.frame_ready", 32'(frame_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model_frame[i] = 0;

        // After reset, zeros with only slot 0 shown when blanking is on.
        set_mode(1'b1, 1'b0);
        chk("post.frame_ready", 32'(frame_ready), 32'd0);
        check_window("post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
